// File: rtl/oh_rstseq_pkg.sv
// Shared types and elaboration helpers for the oh_rstseq reset sequencer.
package oh_rstseq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // True when a CW-bit counter can represent max(HOLD, GAP, TMO).
    function automatic bit cw_fits(input int cw, input int hold, input int gap, input int tmo);
        longint m;
        longint lim;
        m = longint'(hold);
        if (longint'(gap) > m) m = longint'(gap);
        if (longint'(tmo) > m) m = longint'(tmo);
        lim = (longint'(1) << cw) - 1;
        return (m <= lim);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oh_rsync.sv
// Reset synchronizer: asynchronous assertion, PS-stage synchronous deassertion.
module oh_rsync #(
    parameter int PS = 2
) (
    input  logic clk_i,
    input  logic nrst_i,
    output logic nrst_o
);

    logic [PS-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[PS-2:0], 1'b1};
        end
    end

    assign nrst_o = pipe_q[PS-1];

endmodule

// File: rtl/oh_rstseq.sv
// Reset sequencer: stretches nrst_in/swrst to HOLD cycles, then releases N resets in order.
// Optional ack handshake with timeout when OH_RSTSEQ_ACK_EN is defined.
module oh_rstseq
    import oh_rstseq_pkg::*;
#(
    parameter int N    = 4,
    parameter int HOLD = 16,
    parameter int GAP  = 8,
    parameter int PS   = 2,
    parameter int TMO  = 255,
    parameter int CW   = 8
) (
    input  logic         clk,
    input  logic         nrst_in,
    input  logic         swrst,
`ifdef OH_RSTSEQ_ACK_EN
    input  logic [N-1:0] ack_in,
    output logic         err,
`endif
    output logic [N-1:0] nrst_out,
    output logic         busy,
    output logic         done
);

    localparam int IW = idx_w(N);

    if (!cw_fits(CW, HOLD, GAP, TMO)) begin : g_bad_cw
        $error("oh_rstseq: CW=%0d cannot hold max(HOLD,GAP,TMO)", CW);
    end
    if (N < 1 || HOLD < 1 || GAP < 1 || PS < 2) begin : g_bad_par
        $error("oh_rstseq: illegal parameter set");
    end

    logic           rst_sync;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   nrst_q, nrst_d, nrst_shl;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef OH_RSTSEQ_ACK_EN
    logic           err_q, err_d;
    logic           ack_ok, tmo_hit;
`endif

    oh_rsync #(.PS(PS)) u_rsync (
        .clk_i  (clk),
        .nrst_i (nrst_in),
        .nrst_o (rst_sync)
    );

    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    // Shifting a 1 in from the bottom keeps the vector thermometer-coded.
    assign nrst_shl = (nrst_q << 1) | N'(1);
`ifdef OH_RSTSEQ_ACK_EN
    assign ack_ok   = ack_in[idx_q];
    assign tmo_hit  = (cnt_q >= CW'(TMO - 1));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nrst_d  = nrst_q;
`ifdef OH_RSTSEQ_ACK_EN
        err_d   = err_q;
`endif
        if (swrst) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            nrst_d  = '0;
`ifdef OH_RSTSEQ_ACK_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (rst_sync) begin
                        if (cnt_q >= CW'(HOLD - 1)) begin
                            nrst_d = N'(1);
                            idx_d  = '0;
                            cnt_d  = '0;
`ifdef OH_RSTSEQ_ACK_EN
                            state_d = ST_RELEASE;
`else
                            state_d = (N == 1) ? ST_DONE : ST_RELEASE;
`endif
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_RELEASE: begin
`ifdef OH_RSTSEQ_ACK_EN
                    // With all bits out, the step only waits for the final ack.
                    if ((cnt_q >= CW'(GAP - 1) && ack_ok) || tmo_hit) begin
                        if (!ack_ok) err_d = 1'b1;
                        cnt_d = '0;
                        if (&nrst_q) begin
                            state_d = ST_DONE;
                        end else begin
                            nrst_d = nrst_shl;
                            idx_d  = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    if (cnt_q >= CW'(GAP - 1)) begin
                        cnt_d  = '0;
                        nrst_d = nrst_shl;
                        idx_d  = idx_q + IW'(1);
                        if (idx_q == IW'(N - 2)) state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`endif
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    nrst_d  = '0;
                end
            endcase
        end
        busy_d = ~(&nrst_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nrst_q  <= nrst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef OH_RSTSEQ_ACK_EN
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign nrst_out = nrst_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_oh_rstseq.sv
// Bench for oh_rstseq (default build): directed timing cases plus randomized resets.
module tb_oh_rstseq;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int PS   = 2;

    logic         clk     = 1'b0;
    logic         nrst_in = 1'b0;
    logic         swrst   = 1'b0;
    logic [N-1:0] nrst_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    // Reference model: qualifying/elapsed edges since the last restart, and sync depth.
    int t_m  = 0;
    int sc_m = 0;

    oh_rstseq #(
        .N(N), .HOLD(HOLD), .GAP(GAP), .PS(PS), .TMO(255), .CW(8)
    ) dut (
        .clk      (clk),
        .nrst_in  (nrst_in),
        .swrst    (swrst),
        .nrst_out (nrst_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            t_m  = 0;
            sc_m = 0;
        end else begin
            if (swrst) t_m = 0;
            else if (sc_m >= PS) t_m++;
            if (sc_m < PS) sc_m++;
        end
    end

    function automatic int n_rel(input int t);
        int k;
        if (t < HOLD) return 0;
        k = 1 + (t - HOLD) / GAP;
        return (k < N) ? k : N;
    endfunction

    function automatic logic [N-1:0] therm(input int k);
        return N'((1 << k) - 1);
    endfunction

    // Released count after POR edge e, straight from the release schedule.
    function automatic int por_k(input int e);
        if (e < 18) return 0;
        if (e < 26) return 1;
        if (e < 34) return 2;
        if (e < 42) return 3;
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_k(input string tag, input int k);
        chk({tag, ".nrst_out"}, 32'(nrst_out), 32'(therm(k)));
        chk({tag, ".busy"},     32'(busy),     32'(k < N));
        chk({tag, ".done"},     32'(done),     32'(k == N));
    endtask

    task automatic chk_model(input string tag);
        chk_k(tag, n_rel(t_m));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int sw_left;
        int r;

        // Power-on release
        repeat (3) @(negedge clk);
        chk_k("por_reset", 0);
        nrst_in = 1'b1;
        for (int e = 1; e <= 44; e++) begin
            @(negedge clk);
            chk_k($sformatf("por_e%0d", e), por_k(e));
            chk_model("por_model");
        end

        // Async reset from DONE, then again while 0011
        #2 nrst_in = 1'b0;
        #1 chk_k("async_from_done", 0);
        @(negedge clk);
        nrst_in = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            chk_k($sformatf("rel2_e%0d", e), por_k(e));
        end
        #2 nrst_in = 1'b0;
        #1 chk_k("async_0011", 0);
        repeat (2) @(negedge clk);
        chk_k("async_hold", 0);
        nrst_in = 1'b1;
        for (int e = 1; e <= 44; e++) begin
            @(negedge clk);
            chk_k($sformatf("rel3_e%0d", e), por_k(e));
            chk_model("rel3_model");
        end

        // Single-cycle swrst in DONE
        swrst = 1'b1;
        @(negedge clk);
        swrst = 1'b0;
        chk_k("sw_k", 0);
        for (int j = 1; j <= 42; j++) begin
            @(negedge clk);
            chk_k($sformatf("sw_k+%0d", j), (j < 16) ? 0 : ((1 + (j - 16) / 8 < 4) ? 1 + (j - 16) / 8 : 4));
            chk_model("sw_model");
        end

        // swrst held 5 cycles once cnt has reached 10 in ASSERT
        #2 nrst_in = 1'b0;
        @(negedge clk);
        nrst_in = 1'b1;
        repeat (12) @(negedge clk);
        swrst = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk_k("swhold_hi", 0);
        end
        swrst = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            chk_k($sformatf("swhold_L+%0d", j), (j < 16) ? 0 : 1);
            chk_model("swhold_model");
        end

        // Randomized swrst pulses and asynchronous reset pulses
        sw_left = 0;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 199));
            if (sw_left > 0) begin
                swrst = 1'b1;
                sw_left--;
            end else if (r < 2) begin
                swrst   = 1'b1;
                sw_left = int'($urandom_range(0, 5));
            end else begin
                swrst = 1'b0;
            end
            if (r == 7) begin
                #2 nrst_in = 1'b0;
                #1 chk_model("rnd_async");
                repeat (int'($urandom_range(0, 2))) begin
                    @(negedge clk);
                    chk_model("rnd_low");
                end
                nrst_in = 1'b1;
            end
            @(negedge clk);
            chk_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
